// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider: controller state
// encoding and iteration-counter sizing.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must reach 2N, so it needs one bit beyond clog2(2N).
  function automatic int cnt_w(input int n);
    return $clog2(2 * n) + 1;
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step #(
  parameter int N = 4
) (
  input  logic [N:0]   rem_i,
  input  logic         q_msb_i,
  input  logic [N-1:0] div_i,
  output logic [N:0]   rem_o,
  output logic         qbit_o
);

  logic [N:0] shifted;
  logic [N:0] trial;

  // The partial remainder is always below the divisor, so bit N of rem_i is
  // zero and the shifted value fits in N+1 bits.
  assign shifted = {rem_i[N-1:0], q_msb_i};
  assign trial   = shifted - {1'b0, div_i};

  always_comb begin
    rem_o  = shifted;
    qbit_o = 1'b0;
    if (!trial[N]) begin
      rem_o  = trial;
      qbit_o = 1'b1;
    end
  end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider: 2N-bit unsigned dividend over N-bit divisor,
// one quotient bit per clock, with the same load/valid handshake as mult2.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [2*N-1:0] q,
  output logic [N-1:0]   r,
  output logic           valid,
  output logic           dz
);

  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(2 * N - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q,   cnt_d;
  logic [N:0]     rem_q,   rem_d;
  logic [2*N-1:0] quo_q,   quo_d;
  logic [N-1:0]   dvs_q,   dvs_d;
  logic [2*N-1:0] q_q,     q_d;
  logic [N-1:0]   r_q,     r_d;
  logic           valid_q, valid_d;
  logic           dz_q,    dz_d;

  logic [N:0]     step_rem;
  logic           step_qbit;

  div_step #(.N(N)) u_step (
    .rem_i   (rem_q),
    .q_msb_i (quo_q[2*N-1]),
    .div_i   (dvs_q),
    .rem_o   (step_rem),
    .qbit_o  (step_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      valid_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_q     <= q_d;
      r_q     <= r_d;
      valid_q <= valid_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_d     = q_q;
    r_d     = r_q;
    valid_d = valid_q;
    dz_d    = dz_q;
    if (load) begin
      quo_d   = dividend;
      dvs_d   = divisor;
      rem_d   = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
      dz_d    = 1'b0;
      state_d = (divisor == '0) ? DONE : RUN;
    end else begin
      case (state_q)
        RUN: begin
          rem_d = step_rem;
          quo_d = {quo_q[2*N-2:0], step_qbit};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            q_d     = {quo_q[2*N-2:0], step_qbit};
            r_d     = step_rem[N-1:0];
            valid_d = 1'b1;
            state_d = DONE;
          end
        end
        // Only a divide-by-zero load reaches DONE with valid still low.
        DONE: begin
          if (!valid_q) begin
            q_d     = '1;
            r_d     = '0;
            dz_d    = 1'b1;
            valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign q     = q_q;
  assign r     = r_q;
  assign valid = valid_q;
  assign dz    = dz_q;

endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div (N=4) with hand-computed results.
module tb_seq_div;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] q;
  logic [3:0] r;
  logic       valid;
  logic       dz;

  int n_cmp = 0;
  int n_err = 0;

  seq_div #(.N(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .dividend (dividend),
    .divisor  (divisor),
    .q        (q),
    .r        (r),
    .valid    (valid),
    .dz       (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [7:0] eq, input logic [3:0] er,
                           input logic edz);
    check_eq({tag, ".valid"}, 32'(valid), 32'd1);
    check_eq({tag, ".q"},     32'(q),     32'(eq));
    check_eq({tag, ".r"},     32'(r),     32'(er));
    check_eq({tag, ".dz"},    32'(dz),    32'(edz));
  endtask

  // Drive a one-cycle load; returns at the negedge just after the load edge.
  task automatic do_load(input logic [7:0] a, input logic [3:0] b);
    dividend = a;
    divisor  = b;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  // From the negedge after the last load edge: valid must stay low for 7
  // more edges and rise on the 8th.
  task automatic wait_result(input string tag, input logic [7:0] eq, input logic [3:0] er);
    repeat (7) @(negedge clk);
    check_eq({tag, ".early"}, 32'(valid), 32'd0);
    @(negedge clk);
    check_res(tag, eq, er, 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check_eq("rst.q",     32'(q),     32'd0);
    check_eq("rst.r",     32'(r),     32'd0);
    check_eq("rst.valid", 32'(valid), 32'd0);
    check_eq("rst.dz",    32'(dz),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_load(8'd8, 4'd4);
    wait_result("8/4", 8'd2, 4'd0);
    #100;
    check_res("8/4.hold", 8'd2, 4'd0, 1'b0);
    @(negedge clk);

    do_load(8'd100, 4'd7);
    wait_result("100/7", 8'd14, 4'd2);
    do_load(8'd255, 4'd1);
    wait_result("255/1", 8'd255, 4'd0);
    do_load(8'd45, 4'd15);
    wait_result("45/15", 8'd3, 4'd0);
    do_load(8'd225, 4'd15);
    wait_result("225/15", 8'd15, 4'd0);

    do_load(8'd77, 4'd0);
    check_eq("dz.early", 32'(valid), 32'd0);
    @(negedge clk);
    check_res("77/0", 8'hFF, 4'd0, 1'b1);
    do_load(8'd9, 4'd3);
    check_eq("dz.clear", 32'(dz), 32'd0);
    wait_result("9/3", 8'd3, 4'd0);

    do_load(8'd200, 4'd9);
    repeat (2) @(negedge clk);
    check_eq("restart.mid", 32'(valid), 32'd0);
    do_load(8'd50, 4'd5);
    wait_result("50/5", 8'd10, 4'd0);

    do_load(8'd200, 4'd9);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("arst.q",     32'(q),     32'd0);
    check_eq("arst.r",     32'(r),     32'd0);
    check_eq("arst.valid", 32'(valid), 32'd0);
    check_eq("arst.dz",    32'(dz),    32'd0);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    dividend = 8'd60;
    divisor  = 4'd4;
    load     = 1'b1;
    repeat (3) @(negedge clk);
    load     = 1'b0;
    check_eq("held.early", 32'(valid), 32'd0);
    wait_result("60/4", 8'd15, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
